// File: rtl/ir_if.sv
// ir_if: instruction register bus (load, scan and immediate select)
interface ir_if;
  logic [15:0] ir_in;
  logic        ir_we;
  logic        imm_sel;
  logic        test;
  logic        sdi;
  logic [15:0] ir;
  logic [15:0] imm;
  modport master (output ir_in, ir_we, imm_sel, test, sdi, input ir, imm);
  modport slave (input ir_in, ir_we, imm_sel, test, sdi, output ir, imm);
endinterface

// File: rtl/ir.sv
// ir: 16-bit instruction register with scan shift and sign-extended immediate
module ir (
  input logic clk,
  input logic rst,
  ir_if.slave bus
);
  logic [15:0] ir_q, ir_d;
  // scan shift wins over load; otherwise hold
  always_comb ir_d = bus.test ? {ir_q[14:0], bus.sdi} : bus.ir_we ? bus.ir_in : ir_q;
  // register with asynchronous clear
  always_ff @(posedge clk or posedge rst)
    if (rst) ir_q <= '0;
    else ir_q <= ir_d;
  assign bus.ir = ir_q;
  assign bus.imm = bus.imm_sel ? {{11{ir_q[4]}}, ir_q[4:0]} : {{8{ir_q[7]}}, ir_q[7:0]};
endmodule

// File: tb/tb_ir.sv
// tb_ir: randomized self-checking bench for ir against a behavioural model
module tb_ir;
  logic clk, rst;
  logic [15:0] m;
  int n_cmp, n_err;
  ir_if bus ();
  ir dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [15:0] imm_of(logic [15:0] v, logic s);
    int x;
    x = s ? int'(v % 32) : int'(v % 256);
    if (s && x >= 16) x -= 32;
    if (!s && x >= 128) x -= 256;
    return 16'(x);
  endfunction
  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    if (!rst) m = bus.test ? {m[14:0], bus.sdi} : bus.ir_we ? bus.ir_in : m;
    #1;
    chk("ir", bus.ir, m);
    chk("imm", bus.imm, imm_of(m, bus.imm_sel));
  endtask
  initial begin
    n_cmp = 0;
    n_err = 0;
    m = '0;
    rst = 1'b1;
    bus.ir_in = 16'h0;
    bus.ir_we = 1'b0;
    bus.imm_sel = 1'b0;
    bus.test = 1'b0;
    bus.sdi = 1'b0;
    #12;
    chk("rst_ir", bus.ir, 16'h0000);
    chk("rst_imm_l", bus.imm, 16'h0000);
    bus.imm_sel = 1'b1;
    #1;
    chk("rst_imm_s", bus.imm, 16'h0000);
    rst = 1'b0;
    bus.ir_in = 16'hFFFF;
    step();
    chk("we0_hold", bus.ir, 16'h0000);
    bus.ir_we = 1'b1;
    step();
    chk("we1_load", bus.ir, 16'hFFFF);
    bus.ir_we = 1'b0;
    bus.ir_in = 16'h001F;
    step();
    chk("we0_keep", bus.ir, 16'hFFFF);
    bus.ir_we = 1'b1;
    bus.imm_sel = 1'b1;
    step();
    chk("short_1f", bus.imm, 16'hFFFF);
    bus.imm_sel = 1'b0;
    #1;
    chk("long_1f", bus.imm, 16'h001F);
    bus.ir_in = 16'h00EF;
    bus.imm_sel = 1'b1;
    step();
    chk("short_ef", bus.imm, 16'h000F);
    bus.imm_sel = 1'b0;
    #1;
    chk("long_ef", bus.imm, 16'hFFEF);
    bus.ir_in = 16'h0000;
    step();
    bus.test = 1'b1;
    bus.sdi = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("scan", bus.ir, 16'((32'd1 << (i + 1)) - 1));
    end
    bus.test = 1'b0;
    bus.ir_in = 16'h1234;
    step();
    bus.ir_in = 16'h5A5A;
    #2;
    rst = 1'b1;
    #1;
    m = '0;
    chk("async_rst", bus.ir, 16'h0000);
    step();
    chk("rst_held", bus.ir, 16'h0000);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_fall", bus.ir, 16'h0000);
    step();
    chk("first_load", bus.ir, 16'h5A5A);
    bus.test = 1'b1;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    m = '0;
    chk("scan_rst", bus.ir, 16'h0000);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bus.ir_in = 16'($urandom);
      bus.ir_we = 1'($urandom);
      bus.test = ($urandom_range(0, 3) == 0);
      bus.sdi = 1'($urandom);
      bus.imm_sel = 1'($urandom);
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        #1;
        m = '0;
        chk("rnd_rst", bus.ir, 16'h0000);
        rst = 1'b0;
      end
      step();
      bus.imm_sel = ~bus.imm_sel;
      #1;
      chk("rnd_sel", bus.imm, imm_of(m, bus.imm_sel));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
